trig_capture: RTL and testbench
===============================

Name: trig_capture

Overview:
- Receiving end of the trigger-out path.
- Collects single-cycle trigger pulses from user logic (for example the counter match flags) into sticky pending bits.
- Delivers the pending bits, together with overrun and activity information, to a reader through a request/valid/ack handshake. Pending state is cleared atomically on read.
- Sits between the trigger sources and the host-facing readout logic, in one clock domain.

Parameters:
- WIDTH, 16, number of trigger bits.
- CNT_W, 8, width of the saturating activity counter.

Ports:
- clk  input  1  block clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ep_trigger  input  WIDTH  trigger pulses; bit i high for one cycle = one event on bit i.
- rd_req  input  1  one-cycle read request.
- rd_ack  input  1  reader has consumed rd_data.
- rd_valid  output  1  rd_data, rd_ovf and rd_count are valid; held high until rd_ack.
- rd_data  output  WIDTH  snapshot of pending bits.
- rd_ovf  output  WIDTH  snapshot of overrun bits.
- rd_count  output  CNT_W  snapshot of activity count.
- pending_any  output  1  OR of the live pending bits.
- rd_busy  output  1  high in state VALID.

Behaviour:
- Reset: all outputs are 0, pending, ovf and count are 0, and the FSM is in IDLE.
- Capture, every cycle in any state:
  - pending[i] is set when ep_trigger[i]=1.
  - ovf[i] is set when ep_trigger[i]=1 while pending[i] is already 1.
  - count increments by 1 in each cycle where any ep_trigger bit is 1, saturating at 2^CNT_W-1 (no wrap).
- FSM states are IDLE and VALID.
- IDLE with rd_req=1, on the same edge:
  - rd_data<=pending, rd_ovf<=ovf, rd_count<=count.
  - pending, ovf and count are cleared, except that triggers arriving in that same cycle are written into the cleared state: pending=ep_trigger, ovf=0, count=(|ep_trigger).
  - rd_valid<=1 and the FSM goes to VALID.
  - Latency from rd_req to rd_valid is 1 cycle. No event is ever lost or double-counted across a read.
- VALID: rd_data, rd_ovf and rd_count hold stable.
  - rd_ack=1 gives rd_valid<=0 and returns the FSM to IDLE.
  - rd_req in VALID is ignored (not queued). Capture continues into the live state.
- rd_ack in IDLE is ignored.
- rd_req and rd_ack together in VALID: the ack is taken and the request is dropped. A new snapshot needs rd_req in IDLE.
- pending_any is combinational from the live pending register.
- Asserting reset_n low mid-transaction immediately clears everything, including an un-acked snapshot.

Optional Feature:
- Macro: TRIG_CAPTURE_EDGE_EN.
- When defined:
  - ep_trigger is treated as levels.
  - A registered copy is kept, and the event is the rising edge (ep_trigger & ~prev). The register prev resets to 0.
  - This adds one register stage, but the event is still recognised in the cycle in which the input rises.
  - A level held high produces exactly one event.
- When undefined:
  - ep_trigger is used directly as the event vector.
  - A level held high for N cycles sets the pending bit, flags an overrun from the second cycle, and adds N to count.

Decomposition:
- A shared package trig_capture_pkg holds:
  - the FSM state enum (IDLE=1'b0, VALID=1'b1);
  - the default WIDTH and CNT_W constants;
  - a saturating-increment function.
- One natural sub-module, trig_capture_bit: a single-bit pending/overrun cell with set, clear-on-read and same-cycle-set-wins logic, instantiated WIDTH times in a generate loop.
- Counter and FSM stay in the top module.

Test Plan:
1. Reset, then pulse ep_trigger=16'h0001, then 16'h8000 three cycles later, then rd_req.
   - Next cycle: rd_valid=1, rd_data=16'h8001, rd_ovf=0, rd_count=2.
   - After rd_ack: rd_valid=0 and pending_any=0.
2. Pulse bit 3 twice before a read.
   - rd_data=16'h0008, rd_ovf=16'h0008, rd_count=2.
3. ep_trigger=16'h0010 in the same cycle as rd_req, with pending=16'h0001.
   - Snapshot: rd_data=16'h0001.
   - Live state afterwards: pending=16'h0010, pending_any=1.
   - A second read returns rd_data=16'h0010 and rd_count=1.
4. With CNT_W=8, hold any trigger active for 300 cycles, then read.
   - rd_count=8'hFF (saturated, no wrap).
5. Issue rd_req while in VALID, then rd_ack.
   - The snapshot is unchanged during VALID.
   - The request is ignored and rd_valid falls one cycle after rd_ack.
   - A fresh rd_req in IDLE is required.
6. Drop reset_n asynchronously mid-VALID.
   - All outputs are 0 immediately.
   - With TRIG_CAPTURE_EDGE_EN, holding ep_trigger[0] high for 5 cycles then reading gives rd_count=1 and rd_ovf=0.

Source files
------------

// File: rtl/trig_capture_pkg.sv
// Shared types and helpers for the trigger capture block.
package trig_capture_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 8;

    // Increment v, holding at 2^w-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trig_capture_bit.sv
// Single trigger bit: sticky pending plus overrun, cleared on read.
module trig_capture_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic ev,
    input  logic clr,
    output logic pending,
    output logic ovf
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else if (clr) begin
            // An event in the clearing cycle lands in the fresh state.
            pending <= ev;
            ovf     <= 1'b0;
        end else if (ev) begin
            pending <= 1'b1;
            if (pending)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/trig_capture.sv
// Trigger capture with clear-on-read snapshot handshake.
// Define TRIG_CAPTURE_EDGE_EN to treat ep_trigger as levels (rising-edge events).
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic             rd_req,
    input  logic             rd_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_ovf,
    output logic [CNT_W-1:0] rd_count,
    output logic             pending_any,
    output logic             rd_busy
);

    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] ovf;
    logic [CNT_W-1:0] count;
    logic             any_ev;
    logic             clr;
    state_t           state;

`ifdef TRIG_CAPTURE_EDGE_EN
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prev <= '0;
        else
            prev <= ep_trigger;
    end

    assign ev = ep_trigger & ~prev;
`else
    assign ev = ep_trigger;
`endif

    assign any_ev      = |ev;
    assign clr         = (state == IDLE) && rd_req;
    assign pending_any = |pending;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        trig_capture_bit u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .ev      (ev[i]),
            .clr     (clr),
            .pending (pending[i]),
            .ovf     (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= CNT_W'(any_ev);
        else if (any_ev)
            count <= CNT_W'(sat_inc(32'(count), CNT_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_busy  <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= '0;
            rd_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        rd_data  <= pending;
                        rd_ovf   <= ovf;
                        rd_count <= count;
                        rd_valid <= 1'b1;
                        rd_busy  <= 1'b1;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    // Requests here are dropped, even alongside an ack.
                    if (rd_ack) begin
                        rd_valid <= 1'b0;
                        rd_busy  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                    rd_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_capture.sv
// Directed self-checking bench for trig_capture (default and edge builds).
module tb_trig_capture;

    logic        clk;
    logic        reset_n;
    logic [15:0] ep_trigger;
    logic        rd_req;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] rd_ovf;
    logic [7:0]  rd_count;
    logic        pending_any;
    logic        rd_busy;

    int checks   = 0;
    int failures = 0;

    trig_capture #(.WIDTH(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ep_trigger  (ep_trigger),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ovf      (rd_ovf),
        .rd_count    (rd_count),
        .pending_any (pending_any),
        .rd_busy     (rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"},  32'(rd_data),  32'd0);
        check({tag, "_ovf"},   32'(rd_ovf),   32'd0);
        check({tag, "_count"}, 32'(rd_count), 32'd0);
        check({tag, "_pany"},  32'(pending_any), 32'd0);
        check({tag, "_busy"},  32'(rd_busy),  32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        ep_trigger = '0;
        rd_req     = 1'b0;
        rd_ack     = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Test 1: two separate pulses, then read
        ep_trigger = 16'h0001; tick();
        ep_trigger = 16'h0000; tick(); tick();
        ep_trigger = 16'h8000; tick();
        ep_trigger = 16'h0000;
        check("t1_pany_before", 32'(pending_any), 32'd1);
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_busy",  32'(rd_busy),  32'd1);
        check("t1_data",  32'(rd_data),  32'h8001);
        check("t1_ovf",   32'(rd_ovf),   32'h0000);
        check("t1_count", 32'(rd_count), 32'd2);
        check("t1_pany_cleared", 32'(pending_any), 32'd0);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;
        check("t1_valid_after_ack", 32'(rd_valid), 32'd0);
        check("t1_busy_after_ack",  32'(rd_busy),  32'd0);
        check("t1_pany_after_ack",  32'(pending_any), 32'd0);

        // Test 2: same bit twice -> overrun
        ep_trigger = 16'h0008; tick();
        ep_trigger = 16'h0000; tick();
        ep_trigger = 16'h0008; tick();
        ep_trigger = 16'h0000;
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t2_data",  32'(rd_data),  32'h0008);
        check("t2_ovf",   32'(rd_ovf),   32'h0008);
        check("t2_count", 32'(rd_count), 32'd2);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;

        // Test 3: trigger in the read cycle goes to the fresh live state
        ep_trigger = 16'h0001; tick();
        ep_trigger = 16'h0010; rd_req = 1'b1; tick();
        ep_trigger = 16'h0000; rd_req = 1'b0;
        check("t3_data",  32'(rd_data),  32'h0001);
        check("t3_count", 32'(rd_count), 32'd1);
        check("t3_pany",  32'(pending_any), 32'd1);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t3_data2",  32'(rd_data),  32'h0010);
        check("t3_ovf2",   32'(rd_ovf),   32'h0000);
        check("t3_count2", 32'(rd_count), 32'd1);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;

        // Test 4: 300-cycle hold saturates the counter (default build)
        ep_trigger = 16'h0001;
        for (int i = 0; i < 300; i++) tick();
        ep_trigger = 16'h0000;
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t4_data", 32'(rd_data), 32'h0001);
`ifdef TRIG_CAPTURE_EDGE_EN
        check("t4_count", 32'(rd_count), 32'd1);
        check("t4_ovf",   32'(rd_ovf),   32'h0000);
`else
        check("t4_count", 32'(rd_count), 32'hFF);
        check("t4_ovf",   32'(rd_ovf),   32'h0001);
`endif
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;

        // Test 5: requests in VALID are ignored, snapshot stays put
        ep_trigger = 16'h0004; tick();
        ep_trigger = 16'h0000;
        rd_req = 1'b1; tick();
        check("t5_data",  32'(rd_data),  32'h0004);
        check("t5_count", 32'(rd_count), 32'd1);
        ep_trigger = 16'h0020; tick();
        ep_trigger = 16'h0000; rd_req = 1'b0;
        check("t5_hold_valid", 32'(rd_valid), 32'd1);
        check("t5_hold_data",  32'(rd_data),  32'h0004);
        check("t5_hold_count", 32'(rd_count), 32'd1);
        rd_req = 1'b1; rd_ack = 1'b1; tick();
        rd_req = 1'b0; rd_ack = 1'b0;
        check("t5_valid_after_ack", 32'(rd_valid), 32'd0);
        tick();
        check("t5_req_dropped", 32'(rd_valid), 32'd0);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;
        check("t5_ack_in_idle", 32'(rd_valid), 32'd0);
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t5_fresh_valid", 32'(rd_valid), 32'd1);
        check("t5_fresh_data",  32'(rd_data),  32'h0020);
        check("t5_fresh_count", 32'(rd_count), 32'd1);

        // Test 6: async reset mid-VALID with live pending state
        ep_trigger = 16'h0002; tick();
        ep_trigger = 16'h0000;
        check("t6_pany_live", 32'(pending_any), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick();
        reset_n = 1'b1;
        tick();

        // Level held for 5 cycles
        ep_trigger = 16'h0001;
        for (int i = 0; i < 5; i++) tick();
        ep_trigger = 16'h0000;
        rd_req = 1'b1; tick();
        rd_req = 1'b0;
        check("t6_lvl_data", 32'(rd_data), 32'h0001);
`ifdef TRIG_CAPTURE_EDGE_EN
        check("t6_lvl_count", 32'(rd_count), 32'd1);
        check("t6_lvl_ovf",   32'(rd_ovf),   32'h0000);
`else
        check("t6_lvl_count", 32'(rd_count), 32'd5);
        check("t6_lvl_ovf",   32'(rd_ovf),   32'h0001);
`endif
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;
        check("t6_end_valid", 32'(rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
